// File: rtl/sap1_micro_sequencer_if.sv
// sap1_micro_sequencer_if: run/step/opcode into the sequencer; T-state, SAP-1 control word and status out.
// Control names and polarities match the existing datapath (LM..LO active-low).
interface sap1_micro_sequencer_if #(parameter int CNT_W = 8);
    logic run;
    logic step_mode;
    logic step;
    logic [3:0] opcode;
    logic [5:0] T;
    logic CP, EP, EA, SU, EU;
    logic LM, CE, LI, EI, LA, LB, LO;
    logic halted;
    logic illegal;
    logic busy;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, step_mode, step, opcode,
        output T, CP, EP, EA, SU, EU, LM, CE, LI, EI, LA, LB, LO,
        output halted, illegal, busy, instr_cnt
    );

    modport slave (
        output run, step_mode, step, opcode,
        input  T, CP, EP, EA, SU, EU, LM, CE, LI, EI, LA, LB, LO,
        input  halted, illegal, busy, instr_cnt
    );
endinterface

// File: rtl/sap1_micro_sequencer.sv
// sap1_micro_sequencer: microprogrammed SAP-1 controller with run/pause/step, halt and illegal-opcode detection.
// Controls decode only the registered state plus opcode, so they change solely on clk or async reset.
module sap1_micro_sequencer #(
    parameter bit SKIP_NOP = 1'b1,
    parameter int CNT_W    = 8
) (
    input logic clk,
    input logic rst,
    sap1_micro_sequencer_if.master bus
);
    // One-hot encoding with T1..T6 in the low bits, so T is a direct slice of the state.
    typedef enum logic [8:0] {
        S_T1    = 9'b000000001,
        S_T2    = 9'b000000010,
        S_T3    = 9'b000000100,
        S_T4    = 9'b000001000,
        S_T5    = 9'b000010000,
        S_T6    = 9'b000100000,
        S_IDLE  = 9'b001000000,
        S_PAUSE = 9'b010000000,
        S_HALT  = 9'b100000000
    } state_t;

    state_t st;
    state_t tgt;
    logic step_q;
    logic illegal_q;
    logic [CNT_W-1:0] cnt;
    logic lda, add, sub, out, hlt, legal, alu_op, mem_op;
    logic t1, t2, t3, t4, t5, t6;
    logic last, step_rise;

    assign lda    = bus.opcode == 4'b0000;
    assign add    = bus.opcode == 4'b0001;
    assign sub    = bus.opcode == 4'b0010;
    assign out    = bus.opcode == 4'b1110;
    assign hlt    = bus.opcode == 4'b1111;
    assign legal  = lda || add || sub || out || hlt;
    assign alu_op = add || sub;
    assign mem_op = lda || alu_op;

    assign t1 = st == S_T1;
    assign t2 = st == S_T2;
    assign t3 = st == S_T3;
    assign t4 = st == S_T4;
    assign t5 = st == S_T5;
    assign t6 = st == S_T6;

    assign step_rise = bus.step && !step_q;

    // Instruction boundary: HLT always stops at T4; the rest shorten only when SKIP_NOP is set.
    assign last = (t4 && (hlt || (SKIP_NOP && (out || !legal)))) || (t5 && SKIP_NOP && lda) || t6;
    assign tgt  = (t4 && hlt) ? S_HALT : !bus.run ? S_IDLE : bus.step_mode ? S_PAUSE : S_T1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            step_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt       <= '0;
        end else begin
            step_q <= bus.step;
            if (t4 && !legal) illegal_q <= 1'b1;
            if (last && !(&cnt)) cnt <= cnt + 1'b1;
            if (last) st <= tgt;
            else begin
                case (st)
                    S_IDLE:  st <= bus.run ? S_T1 : S_IDLE;
                    S_PAUSE: st <= !bus.run ? S_IDLE : step_rise ? S_T1 : S_PAUSE;
                    S_T1:    st <= S_T2;
                    S_T2:    st <= S_T3;
                    S_T3:    st <= S_T4;
                    S_T4:    st <= S_T5;
                    S_T5:    st <= S_T6;
                    default: st <= st;
                endcase
            end
        end
    end

    assign bus.T         = st[5:0];
    assign bus.busy      = |st[5:0];
    assign bus.halted    = st == S_HALT;
    assign bus.illegal   = illegal_q;
    assign bus.instr_cnt = cnt;

    assign bus.EP = t1;
    assign bus.CP = t2;
    assign bus.EA = t4 && out;
    assign bus.EU = t6 && alu_op;
    assign bus.SU = t6 && sub;
    assign bus.LM = !(t1 || (t4 && mem_op));
    assign bus.CE = !(t3 || (t5 && mem_op));
    assign bus.LI = !t3;
    assign bus.EI = !(t4 && mem_op);
    assign bus.LA = !((t5 && lda) || (t6 && alu_op));
    assign bus.LB = !(t5 && alu_op);
    assign bus.LO = !(t4 && out);
endmodule

// File: tb/tb_sap1_micro_sequencer.sv
// tb_sap1_micro_sequencer: scoreboard bench driving two sequencers (SKIP_NOP=1 and 0) through a SAP-1 datapath model.
`timescale 1ns/1ps
module tb_sap1_micro_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sap1_micro_sequencer_if #(.CNT_W(8)) b0 ();
    sap1_micro_sequencer_if #(.CNT_W(8)) b1 ();

    sap1_micro_sequencer #(.SKIP_NOP(1'b1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    sap1_micro_sequencer #(.SKIP_NOP(1'b0), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] mar;
        logic [7:0] ir;
        logic [7:0] acc;
        logic [7:0] b;
        logic [7:0] outr;
    } dp_t;

    typedef struct {
        int cnt, acc, outr, halted, illegal, cyc;
    } ret_t;

    typedef struct {
        int t, ctl, busy, halted, illegal, cnt, acc;
    } snap_t;

    logic [7:0] ram [16];
    dp_t dp0, dp1;
    logic [11:0] c0, c1;
    ret_t rq0[$];
    ret_t rq1[$];
    snap_t sq[$];
    int chk = 0;
    int err = 0;
    int cyc0 = 0, cyc1 = 0;
    logic [7:0] pc0 = 8'd0, pc1 = 8'd0;

    int cyc_s[6] = '{5, 11, 17, 23, 27, 31};
    int cyc_n[6] = '{6, 12, 18, 24, 30, 34};
    int acc_p[6] = '{1, 3, 6, 3, 3, 3};
    int out_p[6] = '{0, 0, 0, 0, 3, 3};

    // Control word order {CP,EP,EA,SU,EU,LM,CE,LI,EI,LA,LB,LO}; all inactive = 12'h07F.
    assign c0 = {b0.CP, b0.EP, b0.EA, b0.SU, b0.EU, b0.LM, b0.CE, b0.LI, b0.EI, b0.LA, b0.LB, b0.LO};
    assign c1 = {b1.CP, b1.EP, b1.EA, b1.SU, b1.EU, b1.LM, b1.CE, b1.LI, b1.EI, b1.LA, b1.LB, b1.LO};
    assign b0.opcode = dp0.ir[7:4];
    assign b1.opcode = dp1.ir[7:4];

    function automatic dp_t dp_next(input dp_t s, input logic [11:0] c);
        dp_t n;
        logic [7:0] alu;
        logic [7:0] w;
        n   = s;
        alu = c[8] ? s.acc - s.b : s.acc + s.b;
        w   = c[10] ? {4'h0, s.pc} : !c[5] ? ram[s.mar] : !c[3] ? {4'h0, s.ir[3:0]} :
              c[9] ? s.acc : c[7] ? alu : 8'h00;
        if (c[11]) n.pc = s.pc + 4'd1;
        if (!c[6]) n.mar = w[3:0];
        if (!c[4]) n.ir = w;
        if (!c[2]) n.acc = w;
        if (!c[1]) n.b = w;
        if (!c[0]) n.outr = w;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) dp0 <= '0;
        else dp0 <= dp_next(dp0, c0);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) dp1 <= '0;
        else dp1 <= dp_next(dp1, c1);
    end

    function automatic void cmp(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk_ret(input string nm, input ret_t e, input int cnt, input int acc,
                                    input int outr, input int h, input int il, input int cyc);
        cmp($sformatf("%s retire cnt", nm), cnt, e.cnt);
        cmp($sformatf("%s acc at retire %0d", nm, e.cnt), acc, e.acc);
        cmp($sformatf("%s out at retire %0d", nm, e.cnt), outr, e.outr);
        cmp($sformatf("%s halted at retire %0d", nm, e.cnt), h, e.halted);
        cmp($sformatf("%s illegal at retire %0d", nm, e.cnt), il, e.illegal);
        cmp($sformatf("%s busy cycles at retire %0d", nm, e.cnt), cyc, e.cyc);
    endfunction

    // Monitor: snapshot requests are checked at the next falling edge; retirements whenever instr_cnt moves.
    always @(negedge clk) begin
        snap_t s;
        ret_t r;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            cmp("snap T", b0.T, s.t);
            cmp("snap ctl", c0, s.ctl);
            cmp("snap busy", b0.busy, s.busy);
            cmp("snap halted", b0.halted, s.halted);
            cmp("snap illegal", b0.illegal, s.illegal);
            cmp("snap cnt", b0.instr_cnt, s.cnt);
            cmp("snap acc", dp0.acc, s.acc);
        end
        if (!rst) begin
            cyc0 = 0;
            cyc1 = 0;
            pc0  = 8'd0;
            pc1  = 8'd0;
        end else begin
            if (b0.instr_cnt != pc0) begin
                if (rq0.size() == 0) cmp("dut0 retire without expectation", b0.instr_cnt, pc0);
                else begin
                    r = rq0.pop_front();
                    chk_ret("dut0", r, b0.instr_cnt, dp0.acc, dp0.outr, b0.halted, b0.illegal, cyc0);
                end
                pc0 = b0.instr_cnt;
            end
            if (b1.instr_cnt != pc1) begin
                if (rq1.size() == 0) cmp("dut1 retire without expectation", b1.instr_cnt, pc1);
                else begin
                    r = rq1.pop_front();
                    chk_ret("dut1", r, b1.instr_cnt, dp1.acc, dp1.outr, b1.halted, b1.illegal, cyc1);
                end
                pc1 = b1.instr_cnt;
            end
            if (b0.busy) cyc0++;
            if (b1.busy) cyc1++;
        end
    end

    task automatic push_ret(input int k, input int cnt, input int acc, input int outr,
                            input int h, input int il, input int cyc);
        ret_t r;
        r = '{cnt: cnt, acc: acc, outr: outr, halted: h, illegal: il, cyc: cyc};
        if (k == 0) rq0.push_back(r);
        else rq1.push_back(r);
    endtask

    task automatic push_snap(input int t, input int ctl, input int busy, input int h,
                             input int il, input int cnt, input int acc);
        snap_t s;
        s = '{t: t, ctl: ctl, busy: busy, halted: h, illegal: il, cnt: cnt, acc: acc};
        sq.push_back(s);
    endtask

    task automatic fail_tmo(input string s);
        chk++;
        err++;
        $display("FAIL timeout %s", s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_t(input logic [5:0] t, input int n);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (b0.T == t && b0.instr_cnt == n[7:0]) return;
        end
        fail_tmo($sformatf("wait T=%b cnt=%0d", t, n));
    endtask

    task automatic wait_cnt(input int n);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (b0.instr_cnt == n[7:0]) return;
        end
        fail_tmo($sformatf("wait cnt=%0d", n));
    endtask

    task automatic load_prog(input bit ill);
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        if (ill) begin
            ram[0] = 8'h50;
            ram[1] = 8'h09;
            ram[2] = 8'hF0;
        end else begin
            ram[0] = 8'h09;
            ram[1] = 8'h1A;
            ram[2] = 8'h1B;
            ram[3] = 8'h2B;
            ram[4] = 8'hE0;
            ram[5] = 8'hF0;
        end
        ram[9]  = 8'h01;
        ram[10] = 8'h02;
        ram[11] = 8'h03;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        b0.run = 1'b0; b0.step_mode = 1'b0; b0.step = 1'b0;
        b1.run = 1'b0; b1.step_mode = 1'b0; b1.step = 1'b0;
        load_prog(1'b0);
        tick();
        push_snap(0, 12'h07F, 0, 0, 0, 0, 0);
        tick();

        // Free run of the full program on both variants
        for (int i = 0; i < 6; i++) begin
            push_ret(0, i + 1, acc_p[i], out_p[i], i == 5, 0, cyc_s[i]);
            push_ret(1, i + 1, acc_p[i], out_p[i], i == 5, 0, cyc_n[i]);
        end
        rst = 1'b1; b0.run = 1'b1; b1.run = 1'b1;
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                tick();
                if (b0.halted && b1.halted) break;
            end
            if (k == 200) fail_tmo("both halted");
        end
        push_snap(0, 12'h07F, 0, 1, 0, 6, 3);
        tick();

        // Single-step mode, with stray pulses mid-instruction and in HALT
        b0.run = 1'b0; b1.run = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) push_ret(0, i + 1, acc_p[i], out_p[i], i == 5, 0, cyc_s[i]);
        rst = 1'b1; b0.step_mode = 1'b1; b0.run = 1'b1;
        wait_cnt(1);
        push_snap(0, 12'h07F, 0, 0, 0, 1, 1);
        tick();
        for (int i = 2; i <= 6; i++) begin
            b0.step = 1'b1;
            tick();
            tick();
            b0.step = 1'b0;
            tick();
            b0.step = 1'b1;
            tick();
            b0.step = 1'b0;
            wait_cnt(i);
            repeat (3) tick();
            push_snap(0, 12'h07F, 0, i == 6, 0, i, acc_p[i-1]);
            tick();
        end
        repeat (2) begin
            b0.step = 1'b1;
            tick();
            tick();
            b0.step = 1'b0;
            tick();
            tick();
        end
        push_snap(0, 12'h07F, 0, 1, 0, 6, 3);
        tick();

        // Illegal opcode followed by LDA and HLT
        b0.run = 1'b0; b0.step_mode = 1'b0;
        do_reset();
        load_prog(1'b1);
        push_ret(0, 1, 0, 0, 0, 1, 4);
        push_ret(0, 2, 1, 0, 0, 1, 9);
        push_ret(0, 3, 1, 0, 1, 1, 13);
        rst = 1'b1; b0.run = 1'b1;
        wait_t(6'b001000, 0);
        push_snap(6'b001000, 12'h07F, 1, 0, 0, 0, 0);
        tick();
        push_snap(6'b000001, 12'h43F, 1, 0, 1, 1, 0);
        wait_cnt(3);
        tick();

        // Run dropped in ADD T2, resume, then async reset in SUB T5
        b0.run = 1'b0;
        do_reset();
        load_prog(1'b0);
        push_ret(0, 1, 1, 0, 0, 0, 5);
        push_ret(0, 2, 3, 0, 0, 0, 11);
        push_ret(0, 3, 6, 0, 0, 0, 17);
        rst = 1'b1; b0.run = 1'b1;
        wait_t(6'b000010, 1);
        b0.run = 1'b0;
        wait_cnt(2);
        repeat (3) tick();
        push_snap(0, 12'h07F, 0, 0, 0, 2, 3);
        tick();
        b0.run = 1'b1;
        wait_t(6'b010000, 3);
        #1;
        rst = 1'b0;
        push_snap(0, 12'h07F, 0, 0, 0, 0, 0);
        tick();
        tick();
        b0.run = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        push_snap(0, 12'h07F, 0, 0, 0, 0, 0);
        tick();
        push_ret(0, 1, 1, 0, 0, 0, 5);
        b0.run = 1'b1;
        wait_t(6'b000010, 0);
        b0.run = 1'b0;
        wait_cnt(1);
        repeat (2) tick();
        push_snap(0, 12'h07F, 0, 0, 0, 1, 1);
        repeat (3) tick();

        while (rq0.size() > 0) begin
            void'(rq0.pop_front());
            fail_tmo("dut0 expected retirement never seen");
        end
        while (rq1.size() > 0) begin
            void'(rq1.pop_front());
            fail_tmo("dut1 expected retirement never seen");
        end
        while (sq.size() > 0) begin
            void'(sq.pop_front());
            fail_tmo("snapshot never checked");
        end
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
